// File: rtl/lenet_pkg.sv
// Shared constants for the LeNet-5 pipeline: bus widths, layer indices,
// result-BRAM region bases and the layer sequencer state encoding.
package lenet_pkg;

  localparam int unsigned DATA_SIZE  = 16;
  localparam int unsigned ADDR_WIDTH = 13;
  localparam int unsigned CNT_W      = 24;
  localparam int unsigned STATE_W    = 2;

  localparam logic [2:0] L_CONV1 = 3'd0;
  localparam logic [2:0] L_POOL1 = 3'd1;
  localparam logic [2:0] L_CONV2 = 3'd2;
  localparam logic [2:0] L_POOL2 = 3'd3;
  localparam logic [2:0] L_FC    = 3'd4;

  // Result regions packed back to back: 6x28x28, 6x14x14, 16x10x10, 16x5x5, 10
  localparam logic [12:0] CONV1_RESULT_BASE = 13'd0;
  localparam logic [12:0] POOL1_RESULT_BASE = 13'd4704;
  localparam logic [12:0] CONV2_RESULT_BASE = 13'd5880;
  localparam logic [12:0] POOL2_RESULT_BASE = 13'd7480;
  localparam logic [12:0] FC_RESULT_BASE    = 13'd7880;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] S_GAP  = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE = 2'd3;

endpackage

// File: rtl/bram_port_mux.sv
// One-hot-select mux of packed per-requester BRAM port signals.
// With no select bit set every output is zero.
module bram_port_mux #(
  parameter int unsigned N  = 5,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 13
) (
  input  logic [N-1:0]    sel,
  input  logic [N-1:0]    req_ena,
  input  logic [N-1:0]    req_wea,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_din,
  output logic            bram_ena,
  output logic            bram_wea,
  output logic [AW-1:0]   bram_addr,
  output logic [DW-1:0]   bram_din
);

  // AND-OR mux; relies on sel being one-hot or zero
  always_comb begin
    bram_ena  = 1'b0;
    bram_wea  = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel[k]) begin
        bram_ena  = bram_ena | req_ena[k];
        bram_wea  = bram_wea | req_wea[k];
        bram_addr = bram_addr | req_addr[k*AW +: AW];
        bram_din  = bram_din | req_din[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/lenet_layer_sched.sv
// LeNet-5 layer sequencer: enables each engine in turn with a one-cycle gap,
// grants result-BRAM port A to the active layer, and aborts on a cycle budget.
module lenet_layer_sched #(
  parameter int unsigned NUM_LAYERS = 5,
  parameter int unsigned DATA_SIZE  = lenet_pkg::DATA_SIZE,
  parameter int unsigned ADDR_WIDTH = lenet_pkg::ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = 2**22
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [2:0]                       err_layer,
  output logic [23:0]                      last_cycles,
  output logic [NUM_LAYERS-1:0]            layer_en,
  input  logic [NUM_LAYERS-1:0]            layer_finish,
  input  logic [NUM_LAYERS-1:0]            layer_bram_ena,
  input  logic [NUM_LAYERS-1:0]            layer_bram_wea,
  input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] layer_bram_addra,
  input  logic [NUM_LAYERS*DATA_SIZE-1:0]  layer_bram_dina,
  output logic                             bram_ena,
  output logic                             bram_wea,
  output logic [ADDR_WIDTH-1:0]            bram_addra,
  output logic [DATA_SIZE-1:0]             bram_dina
);

  import lenet_pkg::*;

  logic [STATE_W-1:0]    state, state_nxt;
  logic [2:0]            cur, cur_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  busy_nxt, done_nxt, error_nxt;
  logic [2:0]            err_layer_nxt;
  logic [23:0]           last_nxt;
  logic [NUM_LAYERS-1:0] en_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cur         <= L_CONV1;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_layer   <= '0;
      last_cycles <= '0;
      layer_en    <= '0;
    end else begin
      state       <= state_nxt;
      cur         <= cur_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      err_layer   <= err_layer_nxt;
      last_cycles <= last_nxt;
      layer_en    <= en_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cur_nxt       = cur;
    cnt_nxt       = cnt;
    error_nxt     = error;
    err_layer_nxt = err_layer;
    last_nxt      = last_cycles;
    en_nxt        = layer_en;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        en_nxt = '0;
        if (start) begin
          cur_nxt   = L_CONV1;
          cnt_nxt   = '0;
          error_nxt = 1'b0;
          en_nxt    = NUM_LAYERS'(1);
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt + CNT_W'(1);
        // Finish of the active layer wins over a coincident timeout
        if (layer_finish[cur]) begin
          last_nxt  = 24'(cnt + CNT_W'(1));
          en_nxt    = '0;
          state_nxt = S_GAP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          en_nxt        = '0;
          error_nxt     = 1'b1;
          err_layer_nxt = cur;
          state_nxt     = S_IDLE;
        end
      end
      S_GAP: begin
        if (cur == 3'(NUM_LAYERS - 1)) begin
          state_nxt = S_DONE;
        end else begin
          cur_nxt   = cur + 3'd1;
          cnt_nxt   = '0;
          en_nxt    = NUM_LAYERS'(1) << (cur + 3'd1);
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        en_nxt    = '0;
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

  // Grant follows the registered enables, so reset removes it asynchronously
  bram_port_mux #(
    .N  (NUM_LAYERS),
    .DW (DATA_SIZE),
    .AW (ADDR_WIDTH)
  ) u_bram_port_mux (
    .sel       (layer_en),
    .req_ena   (layer_bram_ena),
    .req_wea   (layer_bram_wea),
    .req_addr  (layer_bram_addra),
    .req_din   (layer_bram_dina),
    .bram_ena  (bram_ena),
    .bram_wea  (bram_wea),
    .bram_addr (bram_addra),
    .bram_din  (bram_dina)
  );

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Bench for lenet_layer_sched: stub engines, expected enable sequence in a
// scoreboard queue, plus direct checks of arbitration, timeout and reset.
module tb_lenet_layer_sched;

  localparam int unsigned NL  = 5;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 13;
  localparam int unsigned TMO = 64;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, error;
  logic [2:0]        err_layer;
  logic [23:0]       last_cycles;
  logic [NL-1:0]     layer_en, layer_finish, lb_ena, lb_wea;
  logic [NL*AW-1:0]  lb_addra;
  logic [NL*DW-1:0]  lb_dina;
  logic              bram_ena, bram_wea;
  logic [AW-1:0]     bram_addra;
  logic [DW-1:0]     bram_dina;

  int            fin_after[NL];
  int            en_cnt[NL];
  logic [NL-1:0] fin_force = '0;
  logic          phase_a   = 1'b0;
  logic          phase_r   = 1'b0;

  int            checks  = 0;
  int            errors  = 0;
  logic [NL-1:0] exp_q[$];
  logic [NL-1:0] prev_en = '0;
  int            done_cnt = 0;
  int            gap_cnt  = 0;
  int            en_len   = 0;
  int            last_len = 0;

  lenet_layer_sched #(
    .NUM_LAYERS (NL),
    .DATA_SIZE  (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .err_layer        (err_layer),
    .last_cycles      (last_cycles),
    .layer_en         (layer_en),
    .layer_finish     (layer_finish),
    .layer_bram_ena   (lb_ena),
    .layer_bram_wea   (lb_wea),
    .layer_bram_addra (lb_addra),
    .layer_bram_dina  (lb_dina),
    .bram_ena         (bram_ena),
    .bram_wea         (bram_wea),
    .bram_addra       (bram_addra),
    .bram_dina        (bram_dina)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stub engines: count enabled cycles, finish in the fin_after-th one
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(NL); k++) en_cnt[k] <= 0;
    end else begin
      for (int k = 0; k < int'(NL); k++) en_cnt[k] <= layer_en[k] ? en_cnt[k] + 1 : 0;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NL); k++)
      layer_finish[k] = fin_force[k] |
                        (layer_en[k] && fin_after[k] != 0 && en_cnt[k] == fin_after[k] - 1);
    lb_ena   = '0;
    lb_wea   = '0;
    lb_addra = '0;
    lb_dina  = '0;
    lb_ena[1] = layer_en[1];
    lb_wea[1] = layer_en[1];
    lb_addra[1*AW +: AW] = 13'd4704;
    lb_dina[1*DW +: DW]  = 16'h1234;
    if (phase_a) begin
      lb_ena[3] = 1'b1;
      lb_wea[3] = 1'b1;
      lb_addra[3*AW +: AW] = 13'd100;
      lb_dina[3*DW +: DW]  = 16'hdead;
    end
    if (phase_r) begin
      lb_ena[2] = layer_en[2];
      lb_wea[2] = layer_en[2];
      lb_addra[2*AW +: AW] = 13'd200;
      lb_dina[2*DW +: DW]  = 16'h0bad;
    end
  end

  // Scoreboard: each new grant is popped and compared, with its preceding gap
  always @(negedge clk) begin
    if (layer_en != '0) begin
      if (layer_en != prev_en) begin
        if (exp_q.size() == 0) begin
          check("en_unexpected", 32'(layer_en), 0);
        end else begin
          if (exp_q[0] != NL'(1)) check("gap_len", (prev_en == '0) ? gap_cnt : 0, 1);
          check("en_seq", 32'(layer_en), 32'(exp_q.pop_front()));
        end
        en_len <= 1;
      end else begin
        en_len <= en_len + 1;
      end
      gap_cnt <= 0;
    end else begin
      if (prev_en != '0) last_len <= en_len;
      if (busy) gap_cnt <= gap_cnt + 1;
    end
    prev_en <= layer_en;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_en(input logic [NL-1:0] v, input int budget, input string tag);
    int n = 0;
    while (layer_en !== v && n < budget) begin
      sample();
      n++;
    end
    check(tag, 32'(layer_en), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < int'(NL); k++) fin_after[k] = 10;
    #2 rst = 1'b0;
    sample();
    sample();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_err_layer", 32'(err_layer), 0);
    check("rst_last_cycles", 32'(last_cycles), 0);
    check("rst_layer_en", 32'(layer_en), 0);
    check("rst_bram_ena", 32'(bram_ena), 0);
    check("rst_bram_addra", 32'(bram_addra), 0);

    // start held across an edge while in reset is lost
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    sample();
    check("start_in_rst_busy", 32'(busy), 0);
    check("start_in_rst_en", 32'(layer_en), 0);

    // Full run; layer 3 requests the BRAM throughout
    phase_a = 1'b1;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00100);
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b10000);
    pulse_start();
    sample();
    check("run_en0", 32'(layer_en), 1);
    check("run_busy", 32'(busy), 1);
    check("l0_bram_ena", 32'(bram_ena), 0);
    check("l0_bram_addra", 32'(bram_addra), 0);
    // stray finish for layer 3 and a second start, both while layer 0 runs
    @(posedge clk);
    #1;
    fin_force = 5'b01000;
    start     = 1'b1;
    @(posedge clk);
    #1;
    fin_force = '0;
    start     = 1'b0;
    wait_en(5'b00010, 40, "wait_l1");
    check("l0_last_cycles", 32'(last_cycles), 10);
    check("l1_bram_ena", 32'(bram_ena), 1);
    check("l1_bram_wea", 32'(bram_wea), 1);
    check("l1_bram_addra", 32'(bram_addra), 4704);
    check("l1_bram_dina", 32'(bram_dina), 32'h1234);
    n = 0;
    while (!done && n < 200) begin
      sample();
      n++;
    end
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 1);
    sample();
    check("done_one_cycle", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("done_count", done_cnt, 1);
    check("last_cycles", 32'(last_cycles), 10);
    check("last_len", last_len, 10);
    check("run_error", 32'(error), 0);
    check("queue_empty_a", exp_q.size(), 0);
    phase_a = 1'b0;

    // Layer 2 never finishes
    fin_after[2] = 0;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00100);
    pulse_start();
    n = 0;
    while (!error && n < 400) begin
      sample();
      n++;
    end
    check("tmo_error", 32'(error), 1);
    check("tmo_err_layer", 32'(err_layer), 2);
    check("tmo_layer_en", 32'(layer_en), 0);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_en_cycles", last_len, int'(TMO));
    check("tmo_last_cycles", 32'(last_cycles), 10);
    sample();
    sample();
    check("tmo_no_done", done_cnt, 1);
    check("tmo_error_sticky", 32'(error), 1);
    check("queue_empty_b", exp_q.size(), 0);

    // New start clears error; reset while layer 2 writes
    fin_after[2] = 10;
    phase_r = 1'b1;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00100);
    pulse_start();
    sample();
    check("restart_error_clr", 32'(error), 0);
    check("restart_busy", 32'(busy), 1);
    wait_en(5'b00100, 60, "wait_l2");
    check("l2_bram_wea", 32'(bram_wea), 1);
    check("l2_bram_addra", 32'(bram_addra), 200);
    #1 rst = 1'b0;
    #1;
    check("arst_bram_ena", 32'(bram_ena), 0);
    check("arst_bram_wea", 32'(bram_wea), 0);
    check("arst_layer_en", 32'(layer_en), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_err_layer", 32'(err_layer), 0);
    check("arst_last_cycles", 32'(last_cycles), 0);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b1;
    phase_r = 1'b0;
    sample();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_done", 32'(done), 0);
    check("queue_empty_c", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
